// File: rtl/level_if.sv
// Handshake and level bus between level_generator (slave) and its controller/consumer (master).
interface level_if #(
    parameter int MAX_NOTES = 4
);
    logic                     new_game;
    logic                     load_level;
    logic                     level_won;
    logic                     level_lost;
    logic [4*MAX_NOTES-1:0]   level_data;
    logic [3:0]               level_length;
    logic                     level_valid;
    logic [3:0]               level_num;
    logic                     game_complete;

    modport master (
        output new_game, load_level, level_won, level_lost,
        input  level_data, level_length, level_valid, level_num, game_complete
    );

    modport slave (
        input  new_game, load_level, level_won, level_lost,
        output level_data, level_length, level_valid, level_num, game_complete
    );
endinterface

// File: rtl/level_generator.sv
// Simon-style level generator: LFSR-driven one-hot notes, one note appended per won level.
// Optional feature LEVEL_REPLAY_ON_LOSS_EN: a loss replays the same level instead of ending the game.
module level_generator #(
    parameter int          MAX_NOTES    = 4,
    parameter int          START_LENGTH = 1,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic   clk,
    input  logic   reset_n,
    level_if.slave bus
);
    localparam int unsigned NSLOT    = MAX_NOTES;
    localparam int unsigned DW       = 4 * MAX_NOTES;
    localparam logic [3:0]  MAX4     = 4'(MAX_NOTES);
    localparam logic [3:0]  START4   = 4'(START_LENGTH);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_READY, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [3:0]      note;
    logic [3:0]      idx;
    logic [DW-1:0]   data;
    logic [3:0]      length;
    logic [3:0]      num;
    logic            valid;
    logic            complete;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign note      = 4'b0001 << lfsr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            lfsr     <= SEED_EFF;
            idx      <= '0;
            data     <= '0;
            length   <= '0;
            num      <= '0;
            valid    <= 1'b0;
            complete <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (bus.new_game) begin
                state    <= S_GEN;
                idx      <= '0;
                data     <= '0;
                length   <= START4;
                num      <= 4'd1;
                valid    <= 1'b0;
                complete <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_GEN: begin
                        for (int unsigned i = 0; i < NSLOT; i++) begin
                            if (idx == 4'(i)) data[DW-1-4*i -: 4] <= note;
                        end
                        idx <= idx + 4'd1;
                        // The last write of the level and READY entry share one edge.
                        if (idx + 4'd1 == length) begin
                            state <= S_READY;
                            valid <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (bus.load_level) begin
                            state <= S_WAIT;
                            valid <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (bus.level_lost) begin
`ifdef LEVEL_REPLAY_ON_LOSS_EN
                            state <= S_READY;
                            valid <= 1'b1;
`else
                            state  <= S_IDLE;
                            idx    <= '0;
                            data   <= '0;
                            length <= '0;
                            num    <= '0;
`endif
                        end else if (bus.level_won) begin
                            if (length < MAX4) begin
                                // idx already equals length, so GEN appends exactly one note.
                                length <= length + 4'd1;
                                num    <= (num < MAX4) ? num + 4'd1 : num;
                                state  <= S_GEN;
                            end else begin
                                state    <= S_DONE;
                                complete <= 1'b1;
                            end
                        end
                    end
                    S_DONE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.level_data    = data;
    assign bus.level_length  = length;
    assign bus.level_valid   = valid;
    assign bus.level_num     = num;
    assign bus.game_complete = complete;
endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator: default instance plus a START_LENGTH=4 instance for restart/reset cases.
module tb_level_generator;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    level_if #(.MAX_NOTES(4)) a_if ();
    level_if #(.MAX_NOTES(4)) b_if ();

    level_generator #(.MAX_NOTES(4), .START_LENGTH(1), .SEED(16'hACE1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if.slave)
    );
    level_generator #(.MAX_NOTES(4), .START_LENGTH(4), .SEED(16'hACE1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if.slave)
    );

    // Reference Galois LFSR, shared by both instances since they share seed and reset.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    function automatic logic [3:0] enc(input logic [15:0] s);
        case (s[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".data"},   64'(a_if.level_data),    64'h0);
        check({tag, ".len"},    64'(a_if.level_length),  64'h0);
        check({tag, ".valid"},  64'(a_if.level_valid),   64'h0);
        check({tag, ".num"},    64'(a_if.level_num),     64'h0);
        check({tag, ".done"},   64'(a_if.game_complete), 64'h0);
    endtask

    task automatic check_b_zero(input string tag);
        check({tag, ".data"},   64'(b_if.level_data),    64'h0);
        check({tag, ".len"},    64'(b_if.level_length),  64'h0);
        check({tag, ".valid"},  64'(b_if.level_valid),   64'h0);
        check({tag, ".num"},    64'(b_if.level_num),     64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] n0, n1, n2, n3;
        logic [3:0] b0, b1, b2, b3;
        logic [15:0] snap;

        a_if.new_game = 0; a_if.load_level = 0; a_if.level_won = 0; a_if.level_lost = 0;
        b_if.new_game = 0; b_if.load_level = 0; b_if.level_won = 0; b_if.level_lost = 0;

        // Reset
        step(); step();
        reset_n = 1'b1;
        check_a_zero("reset_a");
        check_b_zero("reset_b");
        step();

        // First level, default START_LENGTH=1
        a_if.new_game = 1; step(); a_if.new_game = 0;
        check("ng.valid", 64'(a_if.level_valid),  64'h0);
        check("ng.len",   64'(a_if.level_length), 64'd1);
        check("ng.num",   64'(a_if.level_num),    64'd1);
        n0 = enc(m_lfsr);
        step();
        check("l1.valid", 64'(a_if.level_valid), 64'h1);
        check("l1.data",  64'(a_if.level_data),  64'({n0, 12'h000}));

        // level_won ignored in READY
        a_if.level_won = 1; step(); a_if.level_won = 0;
        check("ign_won.valid", 64'(a_if.level_valid),  64'h1);
        check("ign_won.len",   64'(a_if.level_length), 64'd1);
        check("ign_won.data",  64'(a_if.level_data),   64'({n0, 12'h000}));

        a_if.load_level = 1; step(); a_if.load_level = 0;
        check("load.valid", 64'(a_if.level_valid), 64'h0);

        // load_level ignored in WAIT
        a_if.load_level = 1; step(); a_if.load_level = 0;
        check("ign_load.valid", 64'(a_if.level_valid),  64'h0);
        check("ign_load.len",   64'(a_if.level_length), 64'd1);

        // Progression to length 2
        a_if.level_won = 1; step(); a_if.level_won = 0;
        check("w1.valid", 64'(a_if.level_valid),  64'h0);
        check("w1.len",   64'(a_if.level_length), 64'd2);
        check("w1.num",   64'(a_if.level_num),    64'd2);
        n1 = enc(m_lfsr);
        step();
        check("l2.valid", 64'(a_if.level_valid), 64'h1);
        check("l2.data",  64'(a_if.level_data),  64'({n0, n1, 8'h00}));

        // Length 3
        a_if.load_level = 1; step(); a_if.load_level = 0;
        a_if.level_won = 1; step(); a_if.level_won = 0;
        n2 = enc(m_lfsr);
        step();
        check("l3.valid", 64'(a_if.level_valid),  64'h1);
        check("l3.len",   64'(a_if.level_length), 64'd3);
        check("l3.num",   64'(a_if.level_num),    64'd3);
        check("l3.data",  64'(a_if.level_data),   64'({n0, n1, n2, 4'h0}));

        // Length 4
        a_if.load_level = 1; step(); a_if.load_level = 0;
        a_if.level_won = 1; step(); a_if.level_won = 0;
        n3 = enc(m_lfsr);
        step();
        check("l4.valid", 64'(a_if.level_valid),  64'h1);
        check("l4.len",   64'(a_if.level_length), 64'd4);
        check("l4.num",   64'(a_if.level_num),    64'd4);
        check("l4.data",  64'(a_if.level_data),   64'({n0, n1, n2, n3}));

        // Winning the full-length level completes the game
        a_if.load_level = 1; step(); a_if.load_level = 0;
        a_if.level_won = 1; step(); a_if.level_won = 0;
        check("done.flag",  64'(a_if.game_complete), 64'h1);
        check("done.num",   64'(a_if.level_num),     64'd4);
        check("done.len",   64'(a_if.level_length),  64'd4);
        check("done.valid", 64'(a_if.level_valid),   64'h0);
        check("done.data",  64'(a_if.level_data),    64'({n0, n1, n2, n3}));
        a_if.level_won = 1; a_if.level_lost = 1; step(); a_if.level_won = 0; a_if.level_lost = 0;
        step();
        check("done.hold", 64'(a_if.game_complete), 64'h1);
        check("done.holdlen", 64'(a_if.level_length), 64'd4);

        // new_game leaves DONE
        a_if.new_game = 1; step(); a_if.new_game = 0;
        check("rg.done", 64'(a_if.game_complete), 64'h0);
        check("rg.data", 64'(a_if.level_data),    64'h0);
        n0 = enc(m_lfsr);
        step();
        check("rg.valid", 64'(a_if.level_valid), 64'h1);
        check("rg.l1",    64'(a_if.level_data),  64'({n0, 12'h000}));

        // Simultaneous won+lost in WAIT: loss wins
        a_if.load_level = 1; step(); a_if.load_level = 0;
        a_if.level_won = 1; a_if.level_lost = 1; step(); a_if.level_won = 0; a_if.level_lost = 0;
`ifdef LEVEL_REPLAY_ON_LOSS_EN
        check("both.valid", 64'(a_if.level_valid),  64'h1);
        check("both.len",   64'(a_if.level_length), 64'd1);
        check("both.num",   64'(a_if.level_num),    64'd1);
        check("both.data",  64'(a_if.level_data),   64'({n0, 12'h000}));
        a_if.load_level = 1; step(); a_if.load_level = 0;
        a_if.level_lost = 1; step(); a_if.level_lost = 0;
        check("lost.valid", 64'(a_if.level_valid),  64'h1);
        check("lost.data",  64'(a_if.level_data),   64'({n0, 12'h000}));
        check("lost.len",   64'(a_if.level_length), 64'd1);
`else
        check_a_zero("both");
        // IDLE ignores load/won
        a_if.load_level = 1; a_if.level_won = 1; step(); a_if.load_level = 0; a_if.level_won = 0;
        step();
        check_a_zero("idle");
`endif

        // Restart mid-GEN on START_LENGTH=4 instance
        b_if.new_game = 1; step(); b_if.new_game = 0;
        step();
        b_if.new_game = 1; step(); b_if.new_game = 0;
        check("rs.valid", 64'(b_if.level_valid),  64'h0);
        check("rs.num",   64'(b_if.level_num),    64'd1);
        check("rs.len",   64'(b_if.level_length), 64'd4);
        check("rs.data",  64'(b_if.level_data),   64'h0);
        b0 = enc(m_lfsr); step();
        check("rs.v1", 64'(b_if.level_valid), 64'h0);
        b1 = enc(m_lfsr); step();
        check("rs.v2", 64'(b_if.level_valid), 64'h0);
        b2 = enc(m_lfsr); step();
        check("rs.v3", 64'(b_if.level_valid), 64'h0);
        b3 = enc(m_lfsr); step();
        check("rs.v4",   64'(b_if.level_valid), 64'h1);
        check("rs.num4", 64'(b_if.level_num),   64'd1);
        check("rs.data4", 64'(b_if.level_data), 64'({b0, b1, b2, b3}));
        snap = b_if.level_data;
        step();
        check("rs.hold", 64'(b_if.level_data), 64'(snap));

        // Reset mid-GEN: outputs drop before any clock edge
        b_if.new_game = 1; step(); b_if.new_game = 0;
        step();
        #2 reset_n = 1'b0;
        #1;
        check_b_zero("rst_gen_b");
        check_a_zero("rst_gen_a");
        #2 reset_n = 1'b1;
        step(); step(); step(); step(); step();
        check_b_zero("post_rst_b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/level_generator.md
# level_generator

Produces the note sequences that the playback and response stages consume, and sits directly upstream of `game_core`. Each level is packed into one 4-bit one-hot nibble per note, with the first note to be played in the top nibble, together with the level length. A free-running LFSR supplies the notes. Progression follows Simon rules: a won level keeps its notes and appends one new random note, until `MAX_NOTES` is reached.

## Interface
- `MAX_NOTES`, default 4: slots in `level_data`; legal range 1..15.
- `START_LENGTH`, default 1: notes in the first level; legal range 1..`MAX_NOTES`.
- `SEED`, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  start or restart pulse; accepted in any state.
- `load_level`  in  1  consumer takes the level; meaningful only while `level_valid`=1.
- `level_won`  in  1  pulse from controller: response completed correctly.
- `level_lost`  in  1  pulse from controller: mistake made.
- `level_data`  out  4*MAX_NOTES  packed notes; slot 0 = [4*MAX_NOTES-1 : 4*MAX_NOTES-4].
- `level_length`  out  4  number of valid notes.
- `level_valid`  out  1  level complete and stable.
- `level_num`  out  4  current level number, used for the HEX display.
- `game_complete`  out  1  a `MAX_NOTES`-long level was won.

## Operation
- **Reset values:** all outputs 0, state IDLE, LFSR = `SEED`, write index = 0.
- **LFSR:** 16-bit Galois, mask 16'hB400. It advances every cycle in every state, so user timing adds entropy.
- **Note encoding:** `lfsr[1:0]` selects the note: 00→0001, 01→0010, 10→0100, 11→1000.
- **Slot contents:** every written slot holds exactly one hot bit. Slots at index ≥ `level_length` always read 0.
- **IDLE**
  - On `new_game`: clear `level_data`, set `level_length`=`START_LENGTH`, set `level_num`=1, write index = 0, go to GEN.
- **GEN**
  - Each cycle, write the current note into the slot at the write index and increment the index.
  - When index = `level_length`, go to READY.
- **READY**
  - `level_valid`=1.
  - On `load_level`, go to WAIT.
  - `level_data` and `level_length` hold constant from READY entry until the next GEN.
- **WAIT**
  - `level_valid`=0.
  - On `level_won` with `level_length`<`MAX_NOTES`: increment `level_length` and `level_num`, go to GEN. The write index already points at the new slot, so exactly one note is appended.
  - On `level_won` with `level_length`=`MAX_NOTES`: go to DONE.
  - On `level_lost`: behaviour is set under Configuration.
- **DONE**
  - `game_complete`=1 and the level is retained.
  - Only `new_game` leaves this state.
- **Priorities:**
  - `new_game` overrides everything in every state, including mid-GEN.
  - `level_lost` beats `level_won` when both are asserted in the same cycle.
  - `level_won`/`level_lost` are ignored outside WAIT.
  - `load_level` is ignored outside READY.
- **Width:** `level_length` and `level_num` saturate at `MAX_NOTES`, so they cannot wrap.

## Timing
- `new_game` sampled at edge N: GEN during the L cycles after edge N, where L = `START_LENGTH`.
  - Notes are written at edges N+1..N+L.
  - `level_valid` is high from edge N+L.
- `level_won` sampled at edge M (length < `MAX_NOTES`):
  - The new note is written at edge M+1.
  - `level_valid` is high from edge M+1 (a single GEN cycle).
- `load_level` sampled at edge K: `level_valid` is low from edge K.
- `reset_n` low mid-GEN: immediate return to reset values; a partial level is never presented.

## Configuration
- `LEVEL_REPLAY_ON_LOSS_EN` defined:
  - `level_lost` in WAIT returns to READY with identical `level_data`, `level_length` and `level_num`.
  - The player retries the same level.
- Not defined:
  - `level_lost` in WAIT clears all outputs and returns to IDLE.
  - A new `new_game` is required to play again.

## Test plan
- **Reset:** `reset_n`=0, then release → all outputs 0. `new_game` at edge N with defaults → `level_valid` at N+1; `level_length`=1; `level_data[15:12]` one-hot and equal to the model LFSR note; bits [11:0]=0.
- **Progression:** `load_level`, then `level_won` three times (with a `load_level` between each) → lengths 2,3,4. Each earlier nibble stays unchanged and each new nibble is one-hot. A fourth `level_won` → `game_complete`=1 and `level_num`=4.
- **Simultaneous events:** `level_won` and `level_lost` in the same cycle in WAIT → loss path taken; `level_length` not incremented.
- **Loss:** with `LEVEL_REPLAY_ON_LOSS_EN`, `level_lost` → `level_valid`=1 next cycle with identical data. Without the macro → all outputs 0, state IDLE.
- **Restart/reset mid-GEN:** `START_LENGTH`=4, `new_game` again at GEN cycle 2 → restart, with `level_valid` 4 cycles later and `level_num`=1. `reset_n` pulsed mid-GEN → outputs 0 immediately.
- **Ignored inputs:** `level_won` in READY and `load_level` in WAIT → no state or output change.
